// File: rtl/sub8u_serial_inverse_pkg.sv
// Shared types and constants for the 8-bit unsigned adder family.
// Provides the serial FSM state enum, operand widths and a mod-3 adder.
package sub8u_serial_inverse_pkg;

    localparam int W_OP     = 8;
    localparam int W_SUM    = 9;
    localparam int LAST_BIT = 8;

    // One-hot so that any corrupted encoding is easy to spot.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RUN  = 3'b010,
        DONE = 3'b100
    } state_t;

    // Sum of two residues (each 0..2), reduced back into 0..2.
    function automatic logic [1:0] mod3_add(
        input logic [1:0] x,
        input logic [1:0] y
    );
        logic [2:0] t;
        t = {1'b0, x} + {1'b0, y};
        if (t >= 3'd3) begin
            t = t - 3'd3;
        end
        return t[1:0];
    endfunction

endpackage

// File: rtl/sub8u_serial_inverse_res3.sv
// res3_acc: 2-bit mod-3 accumulator of a bit-serial stream.
// Ports: clk, rst (async high), i_clr, i_en, i_bit, i_odd -> o_acc, o_nxt.
module res3_acc
    import sub8u_serial_inverse_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_bit,
    input  logic       i_odd,
    output logic [1:0] o_acc,
    output logic [1:0] o_nxt
);

    logic [1:0] r_acc;
    logic [1:0] w_add;

    // 2^i mod 3 is 1 for even i and 2 for odd i.
    always_comb begin
        w_add = 2'd0;
        if (i_bit) begin
            w_add = i_odd ? 2'd2 : 2'd1;
        end
    end

    // Next value is exposed so the owner can judge the final bit
    // on the same edge that accumulates it.
    always_comb begin
        o_nxt = r_acc;
        if (i_clr) begin
            o_nxt = 2'd0;
        end else if (i_en) begin
            o_nxt = mod3_add(r_acc, w_add);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= 2'd0;
        end else begin
            r_acc <= o_nxt;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/sub8u_serial_inverse.sv
// Bit-serial A = S - B recovery with range and mod-3 residue checks.
// Ports: clk, rst, in_valid/in_ready, s[8:0], b[7:0],
//        out_valid/out_ready, a[7:0], range_err, res_err.
module sub8u_serial_inverse
    import sub8u_serial_inverse_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W_SUM-1:0]   s,
    input  logic [W_OP-1:0]    b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W_OP-1:0]    a,
    output logic               range_err,
    output logic               res_err
);

    state_t r_state;
    state_t w_state_nxt;

    logic [W_SUM-1:0] r_sr_s;
    logic [W_SUM-1:0] r_sr_b;
    logic [W_SUM-1:0] r_sr_d;
    logic             r_brw;
    logic [3:0]       r_cnt;
    logic             r_range_err;
    logic             r_res_err;

    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic             w_s;
    logic             w_b;
    logic             w_d;
    logic             w_brw_nxt;
    logic [1:0]       w_rs;
    logic [1:0]       w_rb;
    logic [1:0]       w_rd;
    logic [1:0]       w_rs_nxt;
    logic [1:0]       w_rb_nxt;
    logic [1:0]       w_rd_nxt;
    logic [1:0]       w_lhs;
    logic [1:0]       w_rhs;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready    = 1'b1;
                w_state_nxt = in_valid ? RUN : IDLE;
            end
            RUN: begin
                w_state_nxt = w_last ? DONE : RUN;
            end
            DONE: begin
                out_valid   = 1'b1;
                w_state_nxt = out_ready ? IDLE : DONE;
            end
            default: begin
                // Corrupted one-hot: recover through IDLE.
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_load = (r_state == IDLE) && in_valid;
    assign w_step = (r_state == RUN);
    assign w_last = w_step && (r_cnt == 4'(LAST_BIT));

    // ---------------- serial subtractor ----------------
    assign w_s       = r_sr_s[0];
    assign w_b       = r_sr_b[0];
    assign w_d       = w_s ^ w_b ^ r_brw;
    assign w_brw_nxt = (~w_s & w_b) | (~(w_s ^ w_b) & r_brw);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr_s <= '0;
            r_sr_b <= '0;
            r_sr_d <= '0;
            r_brw  <= 1'b0;
            r_cnt  <= 4'd0;
        end else if (w_load) begin
            r_sr_s <= s;
            r_sr_b <= {1'b0, b};
            r_sr_d <= '0;
            r_brw  <= 1'b0;
            r_cnt  <= 4'd0;
        end else if (w_step) begin
            r_sr_s <= {1'b0, r_sr_s[W_SUM-1:1]};
            r_sr_b <= {1'b0, r_sr_b[W_SUM-1:1]};
            r_sr_d <= {w_d, r_sr_d[W_SUM-1:1]};
            r_brw  <= w_brw_nxt;
            r_cnt  <= r_cnt + 4'd1;
        end
    end

    // ---------------- residue accumulators ----------------
    res3_acc u_rs (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_load),
        .i_en  (w_step),
        .i_bit (w_s),
        .i_odd (r_cnt[0]),
        .o_acc (w_rs),
        .o_nxt (w_rs_nxt)
    );

    res3_acc u_rb (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_load),
        .i_en  (w_step),
        .i_bit (w_b),
        .i_odd (r_cnt[0]),
        .o_acc (w_rb),
        .o_nxt (w_rb_nxt)
    );

    res3_acc u_rd (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_load),
        .i_en  (w_step),
        .i_bit (w_d),
        .i_odd (r_cnt[0]),
        .o_acc (w_rd),
        .o_nxt (w_rd_nxt)
    );

    // S - B = D - 512*brw and 512 = 2 (mod 3),
    // so D + B must match S + 2*brw modulo 3.
    assign w_lhs = mod3_add(w_rd_nxt, w_rb_nxt);
    assign w_rhs = mod3_add(w_rs_nxt, w_brw_nxt ? 2'd2 : 2'd0);

    // ---------------- flags ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_range_err <= 1'b0;
            r_res_err   <= 1'b0;
        end else if (w_load) begin
            r_range_err <= 1'b0;
            r_res_err   <= 1'b0;
        end else if (w_last) begin
            // Final borrow means S < B; D[8] means S - B > 255.
            r_range_err <= w_brw_nxt | w_d;
            r_res_err   <= (w_lhs != w_rhs);
        end
    end

    assign a         = r_sr_d[W_OP-1:0];
    assign range_err = r_range_err;
    assign res_err   = r_res_err;

endmodule
